// File: rtl/secuenciador_pixeles_if.sv
// Bus between the filter datapath controller (master) and the pixel
// capture sequencer (slave).
//
// Handshake: there is no back-pressure toward the upstream side. A pixel
// moves in any cycle where the sequencer is in its transfer phase and
// dato_valido is high. guardar_dato is the qualifying strobe seen by the
// register bank in that same cycle. dato_valido low stalls the walk for as
// long as it stays low. iniciar_cambio is a level sampled on every rising
// clock edge. fin_cambio is a single-cycle completion pulse.
interface secuenciador_pixeles_if #(
    parameter int NUM_PIXELES = 4,
    parameter int IDX_W       = (NUM_PIXELES > 1) ? $clog2(NUM_PIXELES) : 1
);
    logic                   iniciar_cambio;
    logic [IDX_W:0]         cantidad;
    logic                   dato_valido;
    logic                   abortar;
    logic [NUM_PIXELES-1:0] guardar_dato;
    logic [IDX_W-1:0]       valor_pixel;
    logic                   ocupado;
    logic                   fin_cambio;

    modport master (
        output iniciar_cambio, cantidad, dato_valido, abortar,
        input  guardar_dato, valor_pixel, ocupado, fin_cambio
    );

    modport slave (
        input  iniciar_cambio, cantidad, dato_valido, abortar,
        output guardar_dato, valor_pixel, ocupado, fin_cambio
    );
endinterface

// File: rtl/secuenciador_pixeles.sv
// Pixel-capture sequencer. It walks a pixel index from 0 to cuenta-1 and
// emits a one-hot store enable for each accepted pixel. It also supports
// stalls, abort, one queued start request and a done pulse.
module secuenciador_pixeles #(
    parameter int NUM_PIXELES = 4,
    parameter int IDX_W       = (NUM_PIXELES > 1) ? $clog2(NUM_PIXELES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    secuenciador_pixeles_if.slave bus,
    output logic [1:0]            estado_dbg
);

    typedef enum logic [1:0] {
        E_INICIO = 2'b00,
        E_CAMBIO = 2'b01,
        E_FIN    = 2'b10
    } estado_t;

    localparam logic [IDX_W:0]         CUENTA_MAX = (IDX_W+1)'(NUM_PIXELES);
    localparam logic [NUM_PIXELES-1:0] UNO        = {{(NUM_PIXELES-1){1'b0}}, 1'b1};

    estado_t          estado, estado_sig;
    logic [IDX_W-1:0] indice, indice_sig;
    logic [IDX_W:0]   cuenta, cuenta_sig;
    logic             pendiente, pendiente_sig;
    logic             ultimo;

    // A count of 0 means the full bank, and anything larger is clamped to the bank size.
    function automatic logic [IDX_W:0] normalizar(input logic [IDX_W:0] c);
        if (c == '0 || int'(c) > NUM_PIXELES)
            return CUENTA_MAX;
        return c;
    endfunction

    assign ultimo     = ({1'b0, indice} == (cuenta - 1'b1));
    assign estado_dbg = estado;

    // State and datapath registers; asynchronous reset forces idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado    <= E_INICIO;
            indice    <= '0;
            cuenta    <= '0;
            pendiente <= 1'b0;
        end else begin
            estado    <= estado_sig;
            indice    <= indice_sig;
            cuenta    <= cuenta_sig;
            pendiente <= pendiente_sig;
        end
    end

    // Next-state and index/count/queue updates; abort overrides everything.
    always_comb begin
        estado_sig    = estado;
        indice_sig    = indice;
        cuenta_sig    = cuenta;
        pendiente_sig = pendiente;
        if (bus.abortar) begin
            estado_sig    = E_INICIO;
            indice_sig    = '0;
            pendiente_sig = 1'b0;
        end else begin
            case (estado)
                E_INICIO: begin
                    if (bus.iniciar_cambio) begin
                        cuenta_sig = normalizar(bus.cantidad);
                        indice_sig = '0;
                        estado_sig = E_CAMBIO;
                    end
                end
                E_CAMBIO: begin
                    // A start during a transfer is remembered once; repeats merge.
                    if (bus.iniciar_cambio)
                        pendiente_sig = 1'b1;
                    if (bus.dato_valido) begin
                        if (ultimo)
                            estado_sig = E_FIN;
                        else
                            indice_sig = indice + 1'b1;
                    end
                end
                E_FIN: begin
                    indice_sig    = '0;
                    pendiente_sig = 1'b0;
                    if (pendiente || bus.iniciar_cambio) begin
                        cuenta_sig = normalizar(bus.cantidad);
                        estado_sig = E_CAMBIO;
                    end else begin
                        estado_sig = E_INICIO;
                    end
                end
                default: begin
                    estado_sig    = E_INICIO;
                    indice_sig    = '0;
                    cuenta_sig    = '0;
                    pendiente_sig = 1'b0;
                end
            endcase
        end
    end

    // Outputs: the store enable is Mealy on dato_valido; the rest follows state.
    always_comb begin
        bus.guardar_dato = '0;
        bus.valor_pixel  = '0;
        bus.ocupado      = 1'b0;
        bus.fin_cambio   = 1'b0;
        case (estado)
            E_CAMBIO: begin
                bus.ocupado     = 1'b1;
                bus.valor_pixel = indice;
                if (bus.dato_valido)
                    bus.guardar_dato = UNO << indice;
            end
            E_FIN: begin
                bus.ocupado    = 1'b1;
                bus.fin_cambio = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_secuenciador_pixeles.sv
// Bench for secuenciador_pixeles: a 4-pixel instance for directed and
// random traffic, and a 9-pixel instance for the wide-index sequence.
module tb_secuenciador_pixeles;

    logic       clk;
    logic       reset;
    logic [1:0] estado4, estado9;

    secuenciador_pixeles_if #(.NUM_PIXELES(4)) bus4 ();
    secuenciador_pixeles_if #(.NUM_PIXELES(9)) bus9 ();

    secuenciador_pixeles #(.NUM_PIXELES(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .estado_dbg(estado4)
    );
    secuenciador_pixeles #(.NUM_PIXELES(9)) dut9 (
        .clk(clk), .reset(reset), .bus(bus9), .estado_dbg(estado9)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters and scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (4-pixel instance) ----------------
    // The model keeps the list of pixel indices still to be stored, a
    // done-pulse flag and a one-deep queued-start flag.
    int m_todo[$];
    bit m_fin;
    bit m_pend;

    function automatic void model_clear();
        m_todo.delete();
        m_fin  = 1'b0;
        m_pend = 1'b0;
    endfunction

    function automatic void model_load(input int cant);
        int n;
        n = (cant == 0 || cant > 4) ? 4 : cant;
        m_todo.delete();
        for (int i = 0; i < n; i++) m_todo.push_back(i);
    endfunction

    function automatic void model_update(input bit ini, input int cant, input bit dv, input bit ab);
        if (ab) begin
            model_clear();
        end else if (m_fin) begin
            m_fin = 1'b0;
            if (m_pend || ini) model_load(cant);
            m_pend = 1'b0;
        end else if (m_todo.size() > 0) begin
            if (ini) m_pend = 1'b1;
            if (dv) begin
                void'(m_todo.pop_front());
                if (m_todo.size() == 0) m_fin = 1'b1;
            end
        end else if (ini) begin
            model_load(cant);
        end
    endfunction

    // Last sampled outputs of the 4-pixel instance, for hand checks.
    logic [3:0] obs_g;
    logic [1:0] obs_vp;
    logic       obs_oc;
    logic       obs_fin;

    // ---------------- driver tasks ----------------
    // Called at posedge+1: drive inputs, compare mid-cycle against the
    // model, then advance the model over the rising edge.
    task automatic step(input bit ini, input logic [2:0] cant, input bit dv, input bit ab);
        logic [3:0] eg;
        logic [1:0] ev;
        logic       eo, ef;
        bus4.iniciar_cambio = ini;
        bus4.cantidad       = cant;
        bus4.dato_valido    = dv;
        bus4.abortar        = ab;
        eg = '0; ev = '0; eo = 1'b0; ef = 1'b0;
        if (m_fin) begin
            eo = 1'b1;
            ef = 1'b1;
        end else if (m_todo.size() > 0) begin
            eo = 1'b1;
            ev = 2'(m_todo[0]);
            if (dv) eg = 4'(1 << m_todo[0]);
        end
        exp_q.push_back(eg);
        #5;
        obs_g   = bus4.guardar_dato;
        obs_vp  = bus4.valor_pixel;
        obs_oc  = bus4.ocupado;
        obs_fin = bus4.fin_cambio;
        chk("model_guardar", obs_g, exp_q.pop_front());
        chk("model_valor", obs_vp, ev);
        chk("model_ocupado", obs_oc, eo);
        chk("model_fin", obs_fin, ef);
        @(posedge clk);
        model_update(ini, int'(cant), dv, ab);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       ini;
        logic [2:0] cant;
        logic       dv;
        logic [3:0] g;
        logic [1:0] vp;
        logic       oc;
        logic       fin;
    } vec_t;

    vec_t tabla[20];

    function automatic vec_t mk(logic ini, logic [2:0] cant, logic dv,
                                logic [3:0] g, logic [1:0] vp, logic oc, logic fin);
        vec_t v;
        v.ini = ini; v.cant = cant; v.dv = dv;
        v.g = g; v.vp = vp; v.oc = oc; v.fin = fin;
        return v;
    endfunction

    initial begin
        int fins;
        bit siempre_ocupado;

        // Full 4-pixel walk with cantidad=0.
        tabla[0]  = mk(1, 3'd0, 0, 4'b0000, 2'd0, 0, 0);
        tabla[1]  = mk(0, 3'd0, 1, 4'b0001, 2'd0, 1, 0);
        tabla[2]  = mk(0, 3'd0, 1, 4'b0010, 2'd1, 1, 0);
        tabla[3]  = mk(0, 3'd0, 1, 4'b0100, 2'd2, 1, 0);
        tabla[4]  = mk(0, 3'd0, 1, 4'b1000, 2'd3, 1, 0);
        tabla[5]  = mk(0, 3'd0, 1, 4'b0000, 2'd0, 1, 1);
        tabla[6]  = mk(0, 3'd0, 0, 4'b0000, 2'd0, 0, 0);
        // Two pixels with dato_valido 1,0,0,1.
        tabla[7]  = mk(1, 3'd2, 0, 4'b0000, 2'd0, 0, 0);
        tabla[8]  = mk(0, 3'd0, 1, 4'b0001, 2'd0, 1, 0);
        tabla[9]  = mk(0, 3'd0, 0, 4'b0000, 2'd1, 1, 0);
        tabla[10] = mk(0, 3'd0, 0, 4'b0000, 2'd1, 1, 0);
        tabla[11] = mk(0, 3'd0, 1, 4'b0010, 2'd1, 1, 0);
        tabla[12] = mk(0, 3'd0, 0, 4'b0000, 2'd0, 1, 1);
        // cantidad=7 clamps to 4; dato_valido ignored while idle.
        tabla[13] = mk(1, 3'd7, 1, 4'b0000, 2'd0, 0, 0);
        tabla[14] = mk(0, 3'd0, 1, 4'b0001, 2'd0, 1, 0);
        tabla[15] = mk(0, 3'd0, 1, 4'b0010, 2'd1, 1, 0);
        tabla[16] = mk(0, 3'd0, 1, 4'b0100, 2'd2, 1, 0);
        tabla[17] = mk(0, 3'd0, 1, 4'b1000, 2'd3, 1, 0);
        tabla[18] = mk(0, 3'd0, 1, 4'b0000, 2'd0, 1, 1);
        tabla[19] = mk(0, 3'd0, 0, 4'b0000, 2'd0, 0, 0);

        // Reset state.
        reset = 1'b0;
        bus4.iniciar_cambio = 0; bus4.cantidad = '0; bus4.dato_valido = 0; bus4.abortar = 0;
        bus9.iniciar_cambio = 0; bus9.cantidad = '0; bus9.dato_valido = 0; bus9.abortar = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        bus4.dato_valido = 1;
        #1;
        chk("rst_guardar", bus4.guardar_dato, 0);
        chk("rst_ocupado", bus4.ocupado, 0);
        chk("rst_fin", bus4.fin_cambio, 0);
        chk("rst_ocupado9", bus9.ocupado, 0);
        bus4.dato_valido = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 20; i++) begin
            bus4.iniciar_cambio = tabla[i].ini;
            bus4.cantidad       = tabla[i].cant;
            bus4.dato_valido    = tabla[i].dv;
            bus4.abortar        = 1'b0;
            #5;
            chk($sformatf("tab%0d_guardar", i), bus4.guardar_dato, tabla[i].g);
            chk($sformatf("tab%0d_valor", i), bus4.valor_pixel, tabla[i].vp);
            chk($sformatf("tab%0d_ocupado", i), bus4.ocupado, tabla[i].oc);
            chk($sformatf("tab%0d_fin", i), bus4.fin_cambio, tabla[i].fin);
            @(posedge clk);
            #1;
        end

        // Queued start during the 2nd pixel: back-to-back sequences.
        model_clear();
        siempre_ocupado = 1'b1;
        step(1, 3'd4, 0, 0);
        step(0, 3'd0, 1, 0);
        siempre_ocupado &= obs_oc;
        step(1, 3'd0, 1, 0);
        siempre_ocupado &= obs_oc;
        chk("cola_idx1", obs_g, 4'b0010);
        step(0, 3'd0, 1, 0);
        siempre_ocupado &= obs_oc;
        step(0, 3'd0, 1, 0);
        siempre_ocupado &= obs_oc;
        step(0, 3'd4, 1, 0);
        siempre_ocupado &= obs_oc;
        chk("cola_fin", obs_fin, 1);
        step(0, 3'd0, 1, 0);
        siempre_ocupado &= obs_oc;
        chk("cola_reinicio", obs_g, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            step(0, 3'd0, 1, 0);
            siempre_ocupado &= obs_oc;
        end
        chk("cola_fin2", obs_fin, 1);
        chk("cola_ocupado_continuo", siempre_ocupado, 1);
        step(0, 3'd0, 0, 0);
        chk("cola_libre", obs_oc, 0);

        // Abort at indice=2 with a pending start.
        step(1, 3'd4, 0, 0);
        step(0, 3'd0, 1, 0);
        step(1, 3'd0, 1, 0);
        step(0, 3'd0, 1, 1);
        chk("abort_guardar_mismo_ciclo", obs_g, 4'b0100);
        step(0, 3'd0, 0, 0);
        chk("abort_ocupado", obs_oc, 0);
        chk("abort_guardar", obs_g, 0);
        chk("abort_fin", obs_fin, 0);
        fins = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 3'd0, 1, 0);
            fins += int'(obs_fin) + int'(obs_oc);
        end
        chk("abort_pendiente_descartado", fins, 0);

        // Asynchronous reset in the middle of a sequence at indice=1.
        step(1, 3'd4, 0, 0);
        step(0, 3'd0, 1, 0);
        bus4.dato_valido = 1;
        #2;
        chk("arst_antes_guardar", bus4.guardar_dato, 4'b0010);
        chk("arst_antes_valor", bus4.valor_pixel, 1);
        reset = 1'b0;
        #1;
        chk("arst_guardar", bus4.guardar_dato, 0);
        chk("arst_valor", bus4.valor_pixel, 0);
        chk("arst_ocupado", bus4.ocupado, 0);
        bus4.dato_valido = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            step(0, 3'd0, 1, 0);
            chk("arst_inactivo", obs_oc, 0);
        end

        // Nine-pixel instance, cantidad=9.
        bus9.iniciar_cambio = 1;
        bus9.cantidad       = 5'd9;
        bus9.dato_valido    = 0;
        #5;
        chk("n9_inicio_ocupado", bus9.ocupado, 0);
        @(posedge clk);
        #1;
        bus9.iniciar_cambio = 0;
        bus9.dato_valido    = 1;
        for (int i = 0; i < 9; i++) begin
            #5;
            chk($sformatf("n9_guardar%0d", i), bus9.guardar_dato, 32'd1 << i);
            chk($sformatf("n9_valor%0d", i), bus9.valor_pixel, i);
            chk($sformatf("n9_fin%0d", i), bus9.fin_cambio, 0);
            @(posedge clk);
            #1;
        end
        #5;
        chk("n9_fin", bus9.fin_cambio, 1);
        chk("n9_fin_guardar", bus9.guardar_dato, 0);
        @(posedge clk);
        #1;
        bus9.dato_valido = 0;
        fins = 0;
        for (int i = 0; i < 3; i++) begin
            #5;
            fins += int'(bus9.fin_cambio) + int'(bus9.ocupado);
            @(posedge clk);
            #1;
        end
        chk("n9_fin_unico", fins, 0);

        // Random traffic against the model.
        model_clear();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 12; i++) step(0, 3'd0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/secuenciador_pixeles.md
Name: secuenciador_pixeles

Overview:
Parametrised pixel-capture sequencer. On a start request it walks a pixel index from 0 to the requested count minus one. Each accepted pixel drives a one-hot store enable to the downstream pixel register bank, plus the binary index to the pixel mux. It adds the following:
- per-request pixel count
- upstream data-valid stall
- abort
- queuing of a single start request
- busy and done status

It sits between the filter datapath controller and the window/pixel register bank.

Parameters:
NUM_PIXELES, 4, number of pixel registers driven (≥2)
IDX_W, $clog2(NUM_PIXELES), width of the pixel index (derived; minimum 1)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
iniciar_cambio  input  1  start request; level sampled each clock
cantidad  input  IDX_W+1  pixels to transfer; sampled only when a sequence starts
dato_valido  input  1  upstream pixel present this cycle
abortar  input  1  synchronous abort
guardar_dato  output  NUM_PIXELES  one-hot store enable for the pixel registers
valor_pixel  output  IDX_W  current pixel index
ocupado  output  1  high when the sequencer is not in E_INICIO
fin_cambio  output  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset (reset=0, asynchronous)
  - State goes to E_INICIO; indice=0, cuenta=0, pendiente=0.
  - All outputs are 0. guardar_dato drops the same cycle reset asserts, including mid-sequence.
  - Exit from reset is synchronous to clk.
- State E_INICIO
  - Outputs: guardar_dato=0, valor_pixel=0, ocupado=0, fin_cambio=0.
  - On iniciar_cambio=1: latch cantidad into cuenta, clear indice, go to E_CAMBIO.
- Count rules, applied at latch time
  - cantidad=0 is treated as NUM_PIXELES.
  - cantidad>NUM_PIXELES is clamped to NUM_PIXELES.
- State E_CAMBIO
  - valor_pixel=indice at all times.
  - guardar_dato = (1<<indice) when dato_valido=1, else 0. This term is a Mealy output, combinational from dato_valido.
  - dato_valido=1 and indice<cuenta-1: indice increments.
  - dato_valido=1 and indice=cuenta-1: go to E_FIN.
  - dato_valido=0: stall; indice holds and no store occurs. Stall length is unbounded.
- State E_FIN (exactly one cycle)
  - Outputs: fin_cambio=1, guardar_dato=0, valor_pixel=0.
  - If pendiente=1 or iniciar_cambio=1: latch cantidad, clear indice, clear pendiente, go to E_CAMBIO (back-to-back sequences).
  - Otherwise go to E_INICIO.
- Start queuing
  - iniciar_cambio=1 while in E_CAMBIO sets pendiente. Depth is one; further requests merge.
- ocupado = 1 in E_CAMBIO and E_FIN.
- Abort
  - abortar=1 in any state: next state E_INICIO; indice and pendiente cleared; no fin_cambio.
  - abortar has priority over dato_valido and iniciar_cambio in the same cycle.
  - The store enable for the current cycle is still asserted if dato_valido=1, because it is combinational.
- Latency
  - First store enable is 1 cycle after the start is sampled.
  - With continuous dato_valido, fin_cambio rises cuenta+1 cycles after the start edge.
- Illegal state encodings recover to E_INICIO on the next clock.

Test Plan:
1. NUM_PIXELES=4, reset then cantidad=0, start pulse, dato_valido=1 continuous → guardar_dato 0001, 0010, 0100, 1000 on consecutive cycles with valor_pixel 0..3, then fin_cambio=1 for one cycle, then ocupado=0.
2. cantidad=2, dato_valido toggling 1,0,0,1 → stores 0001, none, none, 0010; fin_cambio on the 5th cycle after start; cantidad=7 behaves as 4.
3. iniciar_cambio pulsed during the 2nd pixel of a 4-pixel sequence → after fin_cambio, a new sequence begins immediately with guardar_dato=0001 the cycle after E_FIN; ocupado never drops.
4. abortar=1 at indice=2 → next cycle ocupado=0, guardar_dato=0, no fin_cambio; a pending start is discarded.
5. reset driven low at indice=1 asynchronously (between clock edges) → guardar_dato and valor_pixel go to 0 immediately; after release with no start, the block stays idle.
6. NUM_PIXELES=9, cantidad=9 → 9 one-hot enables, valor_pixel 0..8 on the 4-bit index, fin_cambio once.
